// File: rtl/mem_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_ctrl
// Description : Single-port RAM request controller. Accepts read/write
//               requests, drives the RAM port combinationally, and returns
//               read data through a valid/ready response channel holding one
//               response in flight. Optional macro MEM_REQ_CTRL_CLEAR_EN adds
//               a post-reset sweep that zeroes every RAM word.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_ctrl #(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 256,
    parameter int ADDR_W    = $clog2(NUM_WORDS),
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic              ram_rden,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

`ifdef MEM_REQ_CTRL_CLEAR_EN
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RESP  = 2'd2
    } state_t;
    localparam state_t c_RST_STATE = ST_CLEAR;
    // Terminal count compared exactly, so non-power-of-2 depths stop on time
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd1,
        ST_RESP  = 2'd2
    } state_t;
    localparam state_t c_RST_STATE = ST_IDLE;
`endif

    // One extra bit so the range compare works when NUM_WORDS == 2**ADDR_W
    localparam logic [ADDR_W:0] c_NUM_WORDS = (ADDR_W + 1)'(NUM_WORDS);

    state_t state_q, state_d;
    logic   w_accept;
    logic   w_in_range;

    assign w_in_range = ({1'b0, req_addr} < c_NUM_WORDS);
    assign rsp_valid  = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEM_REQ_CTRL_CLEAR_EN
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // Clear sweep address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Next state, handshake and RAM port drive; enables are masked during reset
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        ram_addr  = req_addr;
        ram_wdata = req_wdata;
        ram_wren  = 1'b0;
        ram_rden  = 1'b0;
        w_accept  = 1'b0;
`ifdef MEM_REQ_CTRL_CLEAR_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
`ifdef MEM_REQ_CTRL_CLEAR_EN
            ST_CLEAR: begin
                ram_addr  = cnt_q;
                ram_wdata = '0;
                ram_wren  = rst_n;
                if (cnt_q == c_LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
`endif
            ST_IDLE: begin
                req_ready = 1'b1;
            end
            ST_RESP: begin
                // A new request can only be taken once the held response leaves
                req_ready = rsp_ready;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = c_RST_STATE;
            end
        endcase

        w_accept = req_valid & req_ready & rst_n;
        if (w_accept) begin
            // Out-of-range requests are accepted but never touch the RAM
            if (w_in_range) begin
                ram_wren = req_we;
                ram_rden = ~req_we;
            end
            if (!req_we) begin
                state_d = ST_RESP;
            end
        end
    end

    generate
        if (RD_LAT == 0) begin : g_lat0
            logic [DATA_W-1:0] hold_q, hold_d;

            // Combinational RAM: capture the word at acceptance
            always_comb begin
                hold_d = hold_q;
                if (w_accept && !req_we) begin
                    hold_d = w_in_range ? ram_rdata : '0;
                end
            end

            // Response hold register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_q <= '0;
                end else begin
                    hold_q <= hold_d;
                end
            end

            assign rsp_rdata = hold_q;
        end else begin : g_lat1
            logic              first_q, first_d;
            logic              oor_q, oor_d;
            logic [DATA_W-1:0] hold_q, hold_d;

            // Registered RAM: data appears in the first RESP cycle, capture it then
            always_comb begin
                first_d = w_accept & ~req_we;
                oor_d   = oor_q;
                hold_d  = hold_q;
                if (first_d) begin
                    oor_d = ~w_in_range;
                end
                if (first_q) begin
                    hold_d = oor_q ? '0 : ram_rdata;
                end
            end

            // Response hold register and first-cycle/out-of-range flags
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    first_q <= 1'b0;
                    oor_q   <= 1'b0;
                    hold_q  <= '0;
                end else begin
                    first_q <= first_d;
                    oor_q   <= oor_d;
                    hold_q  <= hold_d;
                end
            end

            // Pass RAM data straight through in the first cycle, then the copy
            assign rsp_rdata = first_q ? (oor_q ? '0 : ram_rdata) : hold_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_ctrl
// Description : Self-checking bench for mem_req_ctrl. Runs one instance per
//               read latency (0 and 1), each with its own RAM model, from a
//               shared stimulus table plus reset/clear sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_ctrl;

    localparam int DW = 32;
    localparam int NW = 10;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_ready;

    logic          req_ready0, rsp_valid0, ram_wren0, ram_rden0, busy0;
    logic [AW-1:0] ram_addr0;
    logic [DW-1:0] rsp_rdata0, ram_wdata0, ram_rdata0;
    logic          req_ready1, rsp_valid1, ram_wren1, ram_rden1, busy1;
    logic [AW-1:0] ram_addr1;
    logic [DW-1:0] rsp_rdata1, ram_wdata1, ram_rdata1;

    logic [DW-1:0] mem0 [0:15];
    logic [DW-1:0] mem1 [0:15];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_req_ctrl #(.DATA_W(DW), .NUM_WORDS(NW), .RD_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0),
        .ram_addr(ram_addr0), .ram_wren(ram_wren0), .ram_rden(ram_rden0),
        .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0), .busy(busy0)
    );

    mem_req_ctrl #(.DATA_W(DW), .NUM_WORDS(NW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1),
        .ram_addr(ram_addr1), .ram_wren(ram_wren1), .ram_rden(ram_rden1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1), .busy(busy1)
    );

    // Combinational-read RAM model
    always @(posedge clk) if (ram_wren0) mem0[ram_addr0] <= ram_wdata0;
    assign ram_rdata0 = mem0[ram_addr0];

    // Registered-read RAM model
    always @(posedge clk) begin
        if (ram_wren1) mem1[ram_addr1] <= ram_wdata1;
        if (ram_rden1) ram_rdata1 <= mem1[ram_addr1];
    end

    typedef struct {
        logic          v, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          rr;
        logic          e_rdy, e_rv;
        logic [DW-1:0] e_rdata;
        logic          e_wren, e_rden, e_busy;
    } vec_t;

    vec_t vt [0:27];

    function automatic vec_t mk(input logic v, we, input logic [AW-1:0] a,
                                input logic [DW-1:0] wd, input logic rr,
                                input logic e_rdy, e_rv, input logic [DW-1:0] e_rdata,
                                input logic e_wren, e_rden, e_busy);
        vec_t t;
        t.v = v; t.we = we; t.addr = a; t.wd = wd; t.rr = rr;
        t.e_rdy = e_rdy; t.e_rv = e_rv; t.e_rdata = e_rdata;
        t.e_wren = e_wren; t.e_rden = e_rden; t.e_busy = e_busy;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk2(input string nm, input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                        input logic [DW-1:0] exp);
        chk({nm, "/lat0"}, a0, exp);
        chk({nm, "/lat1"}, a1, exp);
    endtask

    // Compare every output of both instances against one expectation
    task automatic check_outs(input string nm, input logic rdy, rv, wren, rden, bsy,
                              input logic [DW-1:0] rdata, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wd);
        chk2({nm, " req_ready"}, 32'(req_ready0), 32'(req_ready1), 32'(rdy));
        chk2({nm, " rsp_valid"}, 32'(rsp_valid0), 32'(rsp_valid1), 32'(rv));
        chk2({nm, " ram_wren"},  32'(ram_wren0),  32'(ram_wren1),  32'(wren));
        chk2({nm, " ram_rden"},  32'(ram_rden0),  32'(ram_rden1),  32'(rden));
        chk2({nm, " busy"},      32'(busy0),      32'(busy1),      32'(bsy));
        if (rv) chk2({nm, " rsp_rdata"}, rsp_rdata0, rsp_rdata1, rdata);
        if (wren || rden) chk2({nm, " ram_addr"}, 32'(ram_addr0), 32'(ram_addr1), 32'(addr));
        if (wren) chk2({nm, " ram_wdata"}, ram_wdata0, ram_wdata1, wd);
    endtask

    task automatic drive(input logic v, we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic rr);
        req_valid = v; req_we = we; req_addr = a; req_wdata = wd; rsp_ready = rr;
    endtask

    // Called at a negedge with inputs idle; returns once the block is IDLE
    task automatic release_reset(input string nm);
        rst_n = 1'b1;
        #1;
`ifdef MEM_REQ_CTRL_CLEAR_EN
        for (int i = 0; i < NW; i++) begin
            check_outs($sformatf("%s clear%0d", nm, i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                       '0, AW'(i), '0);
            @(negedge clk);
        end
`endif
        check_outs({nm, " ready"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic check_in_reset(input string nm);
        // A read request is presented on purpose: nothing may reach the RAM
`ifdef MEM_REQ_CTRL_CLEAR_EN
        chk2({nm, " busy"}, 32'(busy0), 32'(busy1), 32'd1);
`else
        chk2({nm, " busy"}, 32'(busy0), 32'(busy1), 32'd0);
`endif
        chk2({nm, " rsp_valid"}, 32'(rsp_valid0), 32'(rsp_valid1), 32'd0);
        chk2({nm, " rsp_rdata"}, rsp_rdata0, rsp_rdata1, 32'd0);
        chk2({nm, " ram_wren"},  32'(ram_wren0),  32'(ram_wren1),  32'd0);
        chk2({nm, " ram_rden"},  32'(ram_rden0),  32'(ram_rden1),  32'd0);
    endtask

    initial begin
        //             v  we addr wdata         rr  rdy rv  rdata        wr rd busy
        vt[0]  = mk(1, 1, 4'd5,  32'hDEADBEEF, 1,  1, 0, 32'h0,        1, 0, 0);
        vt[1]  = mk(1, 0, 4'd5,  32'h0,        1,  1, 0, 32'h0,        0, 1, 0);
        vt[2]  = mk(0, 0, 4'd0,  32'h0,        1,  1, 1, 32'hDEADBEEF, 0, 0, 1);
        vt[3]  = mk(0, 0, 4'd0,  32'h0,        1,  1, 0, 32'h0,        0, 0, 0);
        vt[4]  = mk(1, 1, 4'd1,  32'h11111111, 1,  1, 0, 32'h0,        1, 0, 0);
        vt[5]  = mk(1, 1, 4'd2,  32'h22222222, 1,  1, 0, 32'h0,        1, 0, 0);
        vt[6]  = mk(1, 1, 4'd3,  32'h33333333, 1,  1, 0, 32'h0,        1, 0, 0);
        vt[7]  = mk(1, 1, 4'd7,  32'h77777777, 1,  1, 0, 32'h0,        1, 0, 0);
        vt[8]  = mk(1, 0, 4'd1,  32'h0,        1,  1, 0, 32'h0,        0, 1, 0);
        vt[9]  = mk(1, 0, 4'd2,  32'h0,        1,  1, 1, 32'h11111111, 0, 1, 1);
        vt[10] = mk(1, 0, 4'd3,  32'h0,        1,  1, 1, 32'h22222222, 0, 1, 1);
        vt[11] = mk(0, 0, 4'd0,  32'h0,        1,  1, 1, 32'h33333333, 0, 0, 1);
        vt[12] = mk(0, 0, 4'd0,  32'h0,        1,  1, 0, 32'h0,        0, 0, 0);
        vt[13] = mk(1, 0, 4'd7,  32'h0,        1,  1, 0, 32'h0,        0, 1, 0);
        vt[14] = mk(1, 1, 4'd9,  32'h99999999, 1,  1, 1, 32'h77777777, 1, 0, 1);
        vt[15] = mk(1, 0, 4'd9,  32'h0,        1,  1, 0, 32'h0,        0, 1, 0);
        vt[16] = mk(0, 0, 4'd0,  32'h0,        1,  1, 1, 32'h99999999, 0, 0, 1);
        vt[17] = mk(1, 1, 4'd12, 32'hBAD0BAD0, 1,  1, 0, 32'h0,        0, 0, 0);
        vt[18] = mk(1, 0, 4'd10, 32'h0,        1,  1, 0, 32'h0,        0, 0, 0);
        vt[19] = mk(0, 0, 4'd0,  32'h0,        1,  1, 1, 32'h0,        0, 0, 1);
        vt[20] = mk(0, 0, 4'd0,  32'h0,        1,  1, 0, 32'h0,        0, 0, 0);
        vt[21] = mk(1, 0, 4'd7,  32'h0,        1,  1, 0, 32'h0,        0, 1, 0);
        vt[22] = mk(1, 0, 4'd1,  32'h0,        0,  0, 1, 32'h77777777, 0, 0, 1);
        vt[23] = mk(1, 0, 4'd1,  32'h0,        0,  0, 1, 32'h77777777, 0, 0, 1);
        vt[24] = mk(1, 0, 4'd1,  32'h0,        0,  0, 1, 32'h77777777, 0, 0, 1);
        vt[25] = mk(1, 0, 4'd1,  32'h0,        0,  0, 1, 32'h77777777, 0, 0, 1);
        vt[26] = mk(0, 0, 4'd0,  32'h0,        1,  1, 1, 32'h77777777, 0, 0, 1);
        vt[27] = mk(0, 0, 4'd0,  32'h0,        1,  1, 0, 32'h0,        0, 0, 0);

        // Reset with a read request pending at the inputs
        rst_n = 1'b0;
        drive(1, 0, 4'd3, 32'h0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_in_reset("reset");
        drive(0, 0, 4'd0, 32'h0, 1);
        release_reset("init");

`ifdef MEM_REQ_CTRL_CLEAR_EN
        // Any word reads back as zero after the sweep
        @(posedge clk); #1;
        drive(1, 0, 4'd9, 32'h0, 1);
        @(negedge clk);
        check_outs("clr_rd acc", 1, 0, 0, 1, 0, '0, 4'd9, '0);
        @(posedge clk); #1;
        drive(0, 0, 4'd0, 32'h0, 1);
        @(negedge clk);
        check_outs("clr_rd rsp", 1, 1, 0, 0, 1, 32'h0, '0, '0);
`endif

        @(posedge clk); #1;
        for (int i = 0; i < 28; i++) begin
            drive(vt[i].v, vt[i].we, vt[i].addr, vt[i].wd, vt[i].rr);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vt[i].e_rdy, vt[i].e_rv, vt[i].e_wren,
                       vt[i].e_rden, vt[i].e_busy, vt[i].e_rdata, vt[i].addr, vt[i].wd);
            @(posedge clk); #1;
        end

        // Reset while a response is being held
        drive(1, 0, 4'd2, 32'h0, 1);
        @(negedge clk);
        check_outs("rst_mid acc", 1, 0, 0, 1, 0, '0, 4'd2, '0);
        @(posedge clk); #1;
        drive(1, 0, 4'd3, 32'h0, 0);
        @(negedge clk);
        check_outs("rst_mid hold", 0, 1, 0, 0, 1, 32'h22222222, '0, '0);
        #1 rst_n = 1'b0;
        #1;
        check_in_reset("rst_mid");
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 4'd0, 32'h0, 1);
        release_reset("rst_mid rel");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_outs($sformatf("rst_mid post%0d", i), 1, 0, 0, 0, 0, '0, '0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width.
REQ-002 SHALL have parameter NUM_WORDS, default 256: depth of the attached RAM.
REQ-003 SHALL have parameter ADDR_W, default $clog2(NUM_WORDS): address width.
REQ-004 SHALL have parameter RD_LAT, default 1: RAM read latency; legal values 0 (combinational) and 1 (registered).
REQ-005 SHALL have one clock, clk, with reset asynchronous and active-low on rst_n.
REQ-006 SHALL have ports, in order:
  clk  in  1  clock
  rst_n  in  1  async active-low reset
  req_valid  in  1  request present
  req_ready  out  1  request accepted when high with req_valid
  req_we  in  1  1=write, 0=read
  req_addr  in  ADDR_W  word address
  req_wdata  in  DATA_W  write data
  rsp_valid  out  1  read data present
  rsp_ready  in  1  consumer takes read data
  rsp_rdata  out  DATA_W  read data
  ram_addr  out  ADDR_W  RAM address
  ram_wren  out  1  RAM write enable
  ram_rden  out  1  RAM read enable
  ram_wdata  out  DATA_W  RAM write data
  ram_rdata  in  DATA_W  RAM read data
  busy  out  1  high whenever state is not IDLE

Function
REQ-007 SHALL implement states CLEAR, IDLE and RESP.
REQ-008 req_ready SHALL be 1 in IDLE, 1 in RESP only when rsp_ready=1, and 0 in CLEAR.
REQ-009 On an accepted request, ram_addr=req_addr and the matching enable SHALL be driven combinationally in the same cycle; when nothing is accepted (and not in CLEAR), ram_wren=ram_rden=0.
REQ-010 An accepted write SHALL assert ram_wren for exactly one cycle, with ram_wdata=req_wdata, and SHALL produce no response; IDLE->IDLE, or RESP->IDLE.
REQ-011 An accepted read SHALL assert ram_rden for one cycle and enter RESP; rsp_valid SHALL rise exactly one cycle after acceptance for both RD_LAT values.
REQ-012 RD_LAT=0: ram_rdata SHALL be captured into a hold register at acceptance. RD_LAT=1: ram_rdata SHALL be captured in the first RESP cycle.
REQ-013 rsp_rdata SHALL remain stable while rsp_valid=1 and rsp_ready=0, for any number of cycles.
REQ-014 In RESP with rsp_ready=1 the response SHALL retire; a read accepted in the same cycle SHALL keep RESP, sustaining one read per cycle.
REQ-015 In RESP with rsp_ready=1, a write accepted in the same cycle SHALL enter IDLE.
REQ-016 In RESP with rsp_ready=1 and no accepted request, the block SHALL enter IDLE.
REQ-017 Requests with req_addr >= NUM_WORDS SHALL be accepted with no RAM enable: a write SHALL be dropped; a read SHALL return rsp_rdata=0 with normal timing.
REQ-018 busy SHALL be combinational from state.

Reset
REQ-019 While rst_n=0: state SHALL be CLEAR if the macro is defined, otherwise IDLE; rsp_valid=0, rsp_rdata=0, the hold register=0 and the clear counter=0.
REQ-020 Reset asserted mid-operation SHALL discard any pending response immediately, with no RAM enable asserted during reset.

Configuration
REQ-021 Macro MEM_REQ_CTRL_CLEAR_EN: when defined, CLEAR SHALL be the reset state, and the block SHALL write 0 to addresses 0..NUM_WORDS-1 (one per cycle: ram_wren=1, ram_wdata=0, ram_addr=counter) and then enter IDLE after exactly NUM_WORDS cycles. The terminal count SHALL be NUM_WORDS-1, including for non-power-of-2 depths.
REQ-022 When MEM_REQ_CTRL_CLEAR_EN is undefined, CLEAR and its counter SHALL not exist, and req_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-023 Write 0xDEADBEEF to addr 5, then read addr 5 with rsp_ready=1 -> ram_wren pulses once; rsp_valid=1 with 0xDEADBEEF one cycle after the read is accepted.
REQ-024 Reads of addr 1,2,3 on consecutive cycles, rsp_ready held 1 -> three rsp_valid cycles back-to-back with correct data; req_ready never drops.
REQ-025 Read addr 7, then rsp_ready=0 for 4 cycles -> rsp_rdata constant, req_ready=0 and no RAM enables during the stall; retires on the cycle rsp_ready=1.
REQ-026 With MEM_REQ_CTRL_CLEAR_EN, NUM_WORDS=10: release reset -> 10 zero-writes to addrs 0..9, busy=1 throughout, then req_ready=1; a subsequent read of any address returns 0.
REQ-027 Read accepted, rst_n pulsed low before retire -> rsp_valid=0 immediately and no response after release; read of addr NUM_WORDS -> rsp_rdata=0 and no ram_rden.
